// File: rtl/vga_capture.sv
// rtl/vga_capture.sv - VGA receive side: recovers pixel coordinates from hsync/vsync,
// verifies line/frame timing and emits RRRGGGBB pixel strobes while locked.
module vga_capture #(
   parameter int H_ACTIVE    = 640,
   parameter int H_BACK      = 48,
   parameter int H_TOTAL     = 800,
   parameter int V_ACTIVE    = 480,
   parameter int V_BACK      = 33,
   parameter int V_TOTAL     = 525,
   parameter int LOCK_FRAMES = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       hsync,
   input  logic       vsync,
   input  logic [7:0] red,
   input  logic [7:0] green,
   input  logic [7:0] blue,
   output logic       pix_valid,
   output logic [9:0] pix_x,
   output logic [9:0] pix_y,
   output logic [7:0] pix_data,
   output logic       frame_start,
   output logic       locked,
   output logic       timing_err
);

   localparam logic [9:0] H_FIRST     = 10'(H_BACK);
   localparam logic [9:0] H_END       = 10'(H_BACK + H_ACTIVE);
   localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_FIRST     = 10'(V_BACK);
   localparam logic [9:0] V_END       = 10'(V_BACK + V_ACTIVE);
   localparam logic [9:0] V_LINES     = 10'(V_TOTAL);
   localparam logic [9:0] CNT_MAX     = 10'h3ff;
   localparam logic [3:0] GOOD_NEEDED = 4'(LOCK_FRAMES);

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic       hsync_q, hsync_d;
   logic       vsync_q, vsync_d;
   logic [9:0] hcnt_q, hcnt_d;
   logic [9:0] vcnt_q, vcnt_d;
   logic [3:0] gcnt_q, gcnt_d;
   logic       err_seen_q, err_seen_d;
   logic       pix_valid_q, pix_valid_d;
   logic [9:0] pix_x_q, pix_x_d;
   logic [9:0] pix_y_q, pix_y_d;
   logic [7:0] pix_data_q, pix_data_d;
   logic       frame_start_q, frame_start_d;
   logic       timing_err_q, timing_err_d;

   logic       h_rise, v_rise, line_err, bad_frame, in_window;
   logic       unused_colour_bits;

   assign unused_colour_bits = ^{red[4:0], green[4:0], blue[5:0]};

   always_comb begin
      hsync_d = hsync;
      vsync_d = vsync;
      h_rise  = hsync & ~hsync_q;
      v_rise  = vsync & ~vsync_q;

      // A saturated counter can never equal H_LAST, so overlong lines fail here too.
      line_err  = h_rise && (hcnt_q != H_LAST);
      bad_frame = v_rise && ((vcnt_q != V_LINES) || err_seen_q || line_err);

      hcnt_d = h_rise ? 10'd0 : ((hcnt_q == CNT_MAX) ? hcnt_q : hcnt_q + 10'd1);
      vcnt_d = vcnt_q;
      if (v_rise) begin
         vcnt_d = 10'd0;
      end else if (h_rise && (vcnt_q != CNT_MAX)) begin
         vcnt_d = vcnt_q + 10'd1;
      end
      err_seen_d = v_rise ? 1'b0 : (err_seen_q | line_err);

      in_window = (hcnt_d >= H_FIRST) && (hcnt_d < H_END) &&
                  (vcnt_d >= V_FIRST) && (vcnt_d < V_END);

      state_d = state_q;
      gcnt_d  = gcnt_q;
      case (state_q)
         SEARCH: begin
            if (v_rise) begin
               state_d = VERIFY;
               gcnt_d  = 4'd0;
            end
         end
         VERIFY: begin
            if (line_err || bad_frame) begin
               state_d = SEARCH;
            end else if (v_rise) begin
               gcnt_d = gcnt_q + 4'd1;
               if (gcnt_d == GOOD_NEEDED) begin
                  state_d = LOCKED;
               end
            end
         end
         LOCKED: begin
            if (line_err || bad_frame) begin
               state_d = SEARCH;
            end
         end
         default: state_d = SEARCH;
      endcase

      // Gate on the next state so strobes stop on the very clock an error is seen.
      pix_valid_d   = in_window && (state_d == LOCKED);
      pix_x_d       = pix_valid_d ? (hcnt_d - H_FIRST) : pix_x_q;
      pix_y_d       = pix_valid_d ? (vcnt_d - V_FIRST) : pix_y_q;
      pix_data_d    = pix_valid_d ? {red[7:5], green[7:5], blue[7:6]} : pix_data_q;
      frame_start_d = v_rise && (state_q == LOCKED);
      timing_err_d  = (line_err || bad_frame) && (state_q != SEARCH);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= SEARCH;
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         hcnt_q        <= 10'd0;
         vcnt_q        <= 10'd0;
         gcnt_q        <= 4'd0;
         err_seen_q    <= 1'b0;
         pix_valid_q   <= 1'b0;
         pix_x_q       <= 10'd0;
         pix_y_q       <= 10'd0;
         pix_data_q    <= 8'd0;
         frame_start_q <= 1'b0;
         timing_err_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         hcnt_q        <= hcnt_d;
         vcnt_q        <= vcnt_d;
         gcnt_q        <= gcnt_d;
         err_seen_q    <= err_seen_d;
         pix_valid_q   <= pix_valid_d;
         pix_x_q       <= pix_x_d;
         pix_y_q       <= pix_y_d;
         pix_data_q    <= pix_data_d;
         frame_start_q <= frame_start_d;
         timing_err_q  <= timing_err_d;
      end
   end

   assign pix_valid   = pix_valid_q;
   assign pix_x       = pix_x_q;
   assign pix_y       = pix_y_q;
   assign pix_data    = pix_data_q;
   assign frame_start = frame_start_q;
   assign locked      = (state_q == LOCKED);
   assign timing_err  = timing_err_q;

endmodule
